graybin_sync: RTL
=================

GRAYBIN_SYNC -- requirements
Module: graybin_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the code width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (legal range 2..4).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port gray, input, WIDTH bits: Gray-coded count from an unrelated source; it may change at any time.
REQ-006 The block SHALL have port clr_err, input, 1 bit: synchronous request to clear the step error.
REQ-007 The block SHALL have port binary, output, WIDTH bits: decoded binary value, registered.
REQ-008 The block SHALL have port valid, output, 1 bit: one-cycle pulse when binary takes a new value.
REQ-009 The block SHALL have port delta, output, WIDTH bits: (binary_new - binary_old) mod 2^WIDTH, registered; meaningful only while valid=1.
REQ-010 The block SHALL have port step_err, output, 1 bit: sticky flag for an illegal Gray step.

Function
REQ-011 gray SHALL pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-012 Decode SHALL be binary[WIDTH-1] = g[WIDTH-1] and binary[i] = binary[i+1] XOR g[i], where g is the synchronizer output.
REQ-013 Latency SHALL be SYNC_STAGES+1 clk cycles from a stable gray change to the updated binary and the valid pulse.
REQ-014 valid SHALL be 1 for exactly one cycle whenever the decoded value differs from the held binary; otherwise it SHALL be 0.
REQ-015 An unchanged input SHALL produce no valid pulse and SHALL leave binary and delta held.
REQ-016 The FSM SHALL have three states: INIT, TRACK and ERROR.
REQ-017 INIT SHALL be entered on reset and SHALL last SYNC_STAGES+1 cycles, counted by an internal counter.
REQ-018 In INIT, binary SHALL follow the decode, the step check SHALL be suppressed, and valid and delta SHALL still follow REQ-014 and REQ-009.
REQ-019 When the INIT count expires, the FSM SHALL move INIT -> TRACK.
REQ-020 In TRACK, if consecutive synchronized Gray samples differ in more than one bit, the FSM SHALL move TRACK -> ERROR and step_err SHALL be set.
REQ-021 In ERROR, the FSM SHALL move ERROR -> TRACK on clr_err=1, and step_err SHALL clear on the same edge.
REQ-022 binary, valid and delta SHALL keep updating while in ERROR.
REQ-023 If a violation and clr_err=1 occur in the same cycle, set SHALL win: the FSM stays in or enters ERROR and step_err stays 1.
REQ-024 The wrap from all-ones binary to zero SHALL be a legal single-bit step with delta=1 (WIDTH=4: gray 1000 -> 0000).
REQ-025 A backward single-bit step SHALL be legal, with delta equal to the two's-complement difference (WIDTH=4, binary 5 -> 4 gives delta 4'hF).

Reset
REQ-026 rst=1 SHALL asynchronously clear all synchronizer flops, binary, delta, valid, step_err and the INIT counter, and SHALL force the FSM to INIT.
REQ-027 Reset asserted mid-operation, including while in ERROR, SHALL take effect immediately, and the first post-reset decode SHALL raise no step_err.
REQ-028 Reset deassertion SHALL require no synchronous handling beyond REQ-017.

Configuration
REQ-029 With macro GRAYBIN_STEP_CHECK_EN defined, the block SHALL implement the step check, the ERROR state and step_err as in REQ-020 to REQ-023.
REQ-030 With GRAYBIN_STEP_CHECK_EN undefined, step_err SHALL be constant 0, clr_err SHALL be ignored, the FSM SHALL use only INIT and TRACK, and no Hamming-distance logic SHALL be built.

Structure
REQ-031 Package graybin_pkg SHALL hold the FSM state enum typedef, the gray-to-binary function and the Hamming-distance-greater-than-one function.
REQ-032 The synchronizer chain SHALL be the sub-module gray_sync_chain, parameterized by WIDTH and SYNC_STAGES, with the same clk and rst.
REQ-033 The decode, delta, FSM and error logic SHALL reside in graybin_sync.

Verification (WIDTH=4, SYNC_STAGES=2)
REQ-034 Reset, then drive gray 0000 for 10 cycles -> binary=0, valid never 1, step_err=0.
REQ-035 Step gray through all 16 codes of the sequence 0000, 0001, 0011, ..., 1000, then 0000, one code every 5 cycles -> binary = 0..15 then 0, each valid pulse exactly 3 cycles after its change, delta=1 at every step including the 15 -> 0 wrap.
REQ-036 In TRACK, jump gray 0001 -> 0111 -> step_err=1, binary=5, valid pulse with delta=4; then pulse clr_err -> step_err=0 on the next edge.
REQ-037 Drive a two-bit violation and clr_err=1 in the same cycle -> step_err remains 1 (with GRAYBIN_STEP_CHECK_EN); rebuild without the macro and repeat -> step_err stays 0 throughout.
REQ-038 Hold gray at 1010 while asserting rst for 1 ns mid-cycle -> outputs clear immediately; after release binary=12 with step_err=0.
REQ-039 Drive gray 0111 -> 0110 -> binary 5 -> 4, delta=4'hF, step_err=0.

Source files
------------

// File: rtl/graybin_pkg.sv
// Shared types and helpers for the Gray-code synchronizer/decoder (graybin_sync).
package graybin_pkg;

    localparam int MAX_W = 16;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } gb_state_e;

    // Callers zero-extend narrower codes; leading zeros decode to leading zeros.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Clearing the lowest set bit leaves a nonzero value only if two or more bits differ.
    function automatic logic hd_gt1(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
        logic [MAX_W-1:0] x;
        x = a ^ b;
        return ((x & (x - 16'd1)) != 16'd0);
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous Gray-coded bus into the clk domain.
module gray_sync_chain #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift the sampled code through the synchronizer stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/graybin_sync.sv
// Synchronizes a Gray count, decodes it to binary and reports the step delta.
// Define GRAYBIN_STEP_CHECK_EN to build the multi-bit step check and sticky step_err.
module graybin_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray,
    input  logic             clr_err,
    output logic [WIDTH-1:0] binary,
    output logic             valid,
    output logic [WIDTH-1:0] delta,
    output logic             step_err
);

    import graybin_pkg::*;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(SYNC_STAGES);

    logic [WIDTH-1:0] g_s;
    logic [MAX_W-1:0] g_ext_s;
    logic [WIDTH-1:0] dec_s;
    logic             changed_s;
    logic [WIDTH-1:0] binary_q, binary_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic             valid_q, valid_d;
    gb_state_e        state_q;
    logic [CNT_W-1:0] init_cnt_q;

    gray_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (gray),
        .sync_o  (g_s)
    );

    // Decode the synchronized code and form next binary/valid/delta.
    always_comb begin
        g_ext_s             = {MAX_W{1'b0}};
        g_ext_s[WIDTH-1:0]  = g_s;
        dec_s               = WIDTH'(gray2bin(g_ext_s));
        changed_s           = (dec_s != binary_q);
        binary_d            = dec_s;
        valid_d             = changed_s;
        if (changed_s) begin
            delta_d = dec_s - binary_q;
        end else begin
            delta_d = delta_q;
        end
    end

    // Register the decoded datapath outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            binary_q <= {WIDTH{1'b0}};
            delta_q  <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            binary_q <= binary_d;
            delta_q  <= delta_d;
            valid_q  <= valid_d;
        end
    end

`ifdef GRAYBIN_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_g_q;
    logic [MAX_W-1:0] prev_ext_s;
    logic             viol_s;
    logic             step_err_q;

    // Flag a multi-bit jump between consecutive synchronized samples once out of INIT.
    always_comb begin
        prev_ext_s            = {MAX_W{1'b0}};
        prev_ext_s[WIDTH-1:0] = prev_g_q;
        viol_s                = (state_q != ST_INIT) && hd_gt1(g_ext_s, prev_ext_s);
    end

    // Remember the previous synchronized sample for the step check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_g_q <= {WIDTH{1'b0}};
        end else begin
            prev_g_q <= g_s;
        end
    end

    assign step_err = step_err_q;
`else
    logic unused_clr_s;
    assign unused_clr_s = clr_err;
    assign step_err     = 1'b0;
`endif

    // Mode FSM: INIT masks the flush of reset zeros through the synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= {CNT_W{1'b0}};
`ifdef GRAYBIN_STEP_CHECK_EN
            step_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_q    <= ST_TRACK;
                        init_cnt_q <= {CNT_W{1'b0}};
                    end else begin
                        init_cnt_q <= init_cnt_q + 3'd1;
                    end
                end
                ST_TRACK: begin
`ifdef GRAYBIN_STEP_CHECK_EN
                    if (viol_s) begin
                        state_q    <= ST_ERROR;
                        step_err_q <= 1'b1;
                    end
`endif
                end
`ifdef GRAYBIN_STEP_CHECK_EN
                ST_ERROR: begin
                    // A fresh violation outranks a clear request in the same cycle.
                    if (viol_s) begin
                        step_err_q <= 1'b1;
                    end else if (clr_err) begin
                        state_q    <= ST_TRACK;
                        step_err_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q    <= ST_INIT;
                    init_cnt_q <= {CNT_W{1'b0}};
`ifdef GRAYBIN_STEP_CHECK_EN
                    step_err_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign binary = binary_q;
    assign valid  = valid_q;
    assign delta  = delta_q;

endmodule
